// File: rtl/parc_mem_arb.sv
// parc_mem_arb: round-robin 2:1 memory arbiter for the PARCv2 instruction and data ports.
// An in-order tag FIFO of granted ports steers each memory response back to the port that issued it.
`default_nettype none

module parc_mem_arb #(
  parameter int REQ_SZ          = 67,
  parameter int RESP_SZ         = 35,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [REQ_SZ-1:0]                    imemreq_msg,
  input  logic                                 imemreq_val,
  output logic                                 imemreq_rdy,
  output logic [RESP_SZ-1:0]                   imemresp_msg,
  output logic                                 imemresp_val,
  input  logic [REQ_SZ-1:0]                    dmemreq_msg,
  input  logic                                 dmemreq_val,
  output logic                                 dmemreq_rdy,
  output logic [RESP_SZ-1:0]                   dmemresp_msg,
  output logic                                 dmemresp_val,
  output logic [REQ_SZ-1:0]                    memreq_msg,
  output logic                                 memreq_val,
  input  logic                                 memreq_rdy,
  input  logic [RESP_SZ-1:0]                   memresp_msg,
  input  logic                                 memresp_val,
  output logic [$clog2(MAX_OUTSTANDING):0]     outstanding,
  output logic                                 protocol_err
);

  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int CW = PW + 1;

  logic                       last_grant_q, last_grant_d;
  logic                       hold_q, hold_d;
  logic                       hold_sel_q, hold_sel_d;
  logic                       err_q, err_d;
  logic [MAX_OUTSTANDING-1:0] tags_q, tags_d;
  logic [PW-1:0]              head_q, head_d;
  logic [PW-1:0]              tail_q, tail_d;
  logic [CW-1:0]              count_q, count_d;

  logic sel;
  logic held_val;
  logic hold_live;
  logic full;
  logic req_val;
  logic fire;
  logic nonempty;
  logic pop;
  logic head_tag;

  always_comb begin
    held_val  = hold_sel_q ? dmemreq_val : imemreq_val;
    // A lock on a port that has withdrawn its request is dropped at once so the
    // other port can never be granted under the stale selection.
    hold_live = hold_q & held_val;

    sel = 1'b0;
    if (hold_live) begin
      sel = hold_sel_q;
    end else if (imemreq_val && dmemreq_val) begin
      sel = ~last_grant_q;
    end else if (dmemreq_val) begin
      sel = 1'b1;
    end

    full     = (count_q == CW'(MAX_OUTSTANDING));
    req_val  = reset & (imemreq_val | dmemreq_val) & ~full;
    fire     = req_val & memreq_rdy;
    nonempty = (count_q != '0);
    pop      = memresp_val & nonempty;
    head_tag = tags_q[head_q];
  end

  assign memreq_val   = req_val;
  assign memreq_msg   = sel ? dmemreq_msg : imemreq_msg;
  assign imemreq_rdy  = fire & ~sel;
  assign dmemreq_rdy  = fire & sel;

  assign imemresp_msg = memresp_msg;
  assign dmemresp_msg = memresp_msg;
  assign imemresp_val = reset & pop & ~head_tag;
  assign dmemresp_val = reset & pop & head_tag;

  assign outstanding  = count_q;
  assign protocol_err = err_q;

  always_comb begin
    last_grant_d = last_grant_q;
    hold_d       = hold_live;
    hold_sel_d   = hold_sel_q;
    tags_d       = tags_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    err_d        = err_q | (memresp_val & ~nonempty);

    if (req_val && !memreq_rdy) begin
      hold_d     = 1'b1;
      hold_sel_d = sel;
    end else if (fire) begin
      hold_d       = 1'b0;
      last_grant_d = sel;
    end

    if (fire) begin
      tags_d[tail_q] = sel;
      tail_d         = tail_q + PW'(1);
    end
    if (pop) begin
      head_d = head_q + PW'(1);
    end

    case ({fire, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant_q <= 1'b1;
      hold_q       <= 1'b0;
      hold_sel_q   <= 1'b0;
      err_q        <= 1'b0;
      tags_q       <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      hold_q       <= hold_d;
      hold_sel_q   <= hold_sel_d;
      err_q        <= err_d;
      tags_q       <= tags_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
    end
  end

endmodule

`default_nettype wire
